// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
   typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_t;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus and decode valid/ready bus
interface fetch_unit_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc_plus4;
   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
      input  imem_ack, imem_rdata, if_ready
   );
   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
      output imem_ack, imem_rdata, if_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry valid/ready holding register for instr/pc/pc_plus4
module fetch_buffer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fill,
   input  logic            consume,
   input  logic            flush,
   input  logic [31:0]     d_instr,
   input  logic [XLEN-1:0] d_pc,
   input  logic [XLEN-1:0] d_pc_plus4,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         instr    <= '0;
         pc       <= '0;
         pc_plus4 <= '0;
      end else begin
         // a same-cycle refill wins over the consume
         valid <= !flush && (fill || (valid && !consume));
         if (fill) begin
            instr    <= d_instr;
            pc       <= d_pc;
            pc_plus4 <= d_pc_plus4;
         end
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch with PC, redirect/drain FSM and a
// one-entry output buffer towards decode
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   output logic            misaligned,
   fetch_unit_if.master    bus
);
   fetch_state_t    state, state_n;
   logic [XLEN-1:0] pc, pc_n, redir_pc, redir_pc_n, pc_plus4;
   logic            redir, acc, fill;
   assign pc_plus4      = pc + XLEN'(INSTR_BYTES);
   assign redir         = PCSrc && PCTarget[1:0] == 2'b00;
   // an unacked request in RUN always leaves the buffer empty, so the rule holds req stable
   assign bus.imem_req  = (state == RUN && (!bus.if_valid || bus.if_ready)) || state == DRAIN;
   assign bus.imem_addr = pc;
   assign acc           = bus.imem_req && bus.imem_ack;
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      redir_pc_n = redir_pc;
      fill       = 1'b0;
      case (state)
         BOOT: state_n = RUN;
         RUN: begin
            if (redir && bus.imem_req && !bus.imem_ack) begin
               state_n    = DRAIN;
               redir_pc_n = PCTarget;
            end else if (redir) begin
               pc_n = PCTarget;
            end else if (acc) begin
               fill = 1'b1;
               pc_n = pc_plus4;
            end
         end
         DRAIN: begin
            if (acc) begin
               state_n = RUN;
               pc_n    = redir ? PCTarget : redir_pc;
            end else if (redir) begin
               redir_pc_n = PCTarget;
            end
         end
         default: state_n = BOOT;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         pc         <= RESET_PC;
         redir_pc   <= '0;
         misaligned <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         redir_pc   <= redir_pc_n;
         misaligned <= PCSrc && PCTarget[1:0] != 2'b00;
      end
   end
   fetch_buffer #(.XLEN(XLEN)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .fill       (fill),
      .consume    (bus.if_ready),
      .flush      (redir),
      .d_instr    (bus.imem_rdata),
      .d_pc       (pc),
      .d_pc_plus4 (pc_plus4),
      .valid      (bus.if_valid),
      .instr      (bus.if_instr),
      .pc         (bus.if_pc),
      .pc_plus4   (bus.if_pc_plus4)
   );
endmodule
